vram_arbiter: RTL and testbench

- Sits directly upstream of the video scan-out stage. Owns the single-port 8K x 8 screen RAM, which holds the bitmap at 0x0000-0x17FF and the attributes at 0x1800-0x1AFF.
- Serves the two video reads per 8-pixel cell (bitmap byte, then attribute byte) with absolute priority.
- Interleaves CPU reads and writes into the idle slots.
- Presents each cell's bitmap and attribute bytes as a stable, atomically-updated pair to the scan-out stage.

---
 rtl/vram_arbiter_pkg.sv | 18 +
 rtl/vram_arbiter.sv | 133 +++++++++++++
 tb/tb_vram_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the screen-RAM arbiter: FSM encoding and screen map constants.
package vram_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        V1,
        V2,
        V3,
        C1,
        C2
    } state_t;

    localparam int unsigned BITMAP_BASE = 32'h0000;
    localparam int unsigned ATTR_BASE   = 32'h1800;
    localparam int unsigned SCREEN_END  = 32'h1AFF;
    localparam int unsigned CELL_CLOCKS = 16;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port screen RAM arbiter: video cell fetches (bitmap + attribute) have absolute
// priority, CPU reads/writes fill the idle slots.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_bmp_addr,
    input  logic [AW-1:0] vid_attr_addr,
    output logic [DW-1:0] vid_bmp_data,
    output logic [DW-1:0] vid_attr_data,
    output logic          vid_valid,
    output logic          vid_overrun,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    state_t        state, state_nx;
    logic          vid_pend;
    logic          consume;
    logic [AW-1:0] pend_bmp, pend_attr;
    logic [AW-1:0] cur_bmp, cur_attr;
    logic          cpu_we_q;
    logic [AW-1:0] cpu_addr_q;
    logic [DW-1:0] cpu_wdata_q;
    logic [DW-1:0] bmp_stage;

    assign consume = (state == IDLE) && (vid_pend || vid_req);

    // Pending latch plus a working copy taken at consumption, so a request arriving on the
    // consume edge can re-arm the latch without disturbing the fetch in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_pend    <= 1'b0;
            vid_overrun <= 1'b0;
            pend_bmp    <= '0;
            pend_attr   <= '0;
            cur_bmp     <= '0;
            cur_attr    <= '0;
        end else begin
            if (vid_req) begin
                pend_bmp  <= vid_bmp_addr;
                pend_attr <= vid_attr_addr;
            end
            if (vid_req && vid_pend && !consume)
                vid_overrun <= 1'b1;
            if (consume) begin
                cur_bmp  <= vid_pend ? pend_bmp  : vid_bmp_addr;
                cur_attr <= vid_pend ? pend_attr : vid_attr_addr;
                vid_pend <= vid_pend && vid_req;
            end else if (vid_req) begin
                vid_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cpu_we_q      <= 1'b0;
            cpu_addr_q    <= '0;
            cpu_wdata_q   <= '0;
            bmp_stage     <= '0;
            vid_bmp_data  <= '0;
            vid_attr_data <= '0;
            vid_valid     <= 1'b0;
            cpu_rdata     <= '0;
            cpu_ack       <= 1'b0;
        end else begin
            state     <= state_nx;
            vid_valid <= (state == V3);
            cpu_ack   <= (state == C2);
            if (state == IDLE && state_nx == C1) begin
                cpu_we_q    <= cpu_we;
                cpu_addr_q  <= cpu_addr;
                cpu_wdata_q <= cpu_wdata;
            end
            if (state == V2)
                bmp_stage <= ram_rdata;
            if (state == V3) begin
                vid_bmp_data  <= bmp_stage;
                vid_attr_data <= ram_rdata;
            end
            if (state == C2 && !cpu_we_q)
                cpu_rdata <= ram_rdata;
        end
    end

    always_comb begin
        state_nx  = state;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state)
            IDLE: begin
                if (vid_pend || vid_req)
                    state_nx = V1;
                else if (cpu_req && !cpu_ack)
                    state_nx = C1;
            end
            V1: begin
                ram_addr = cur_bmp;
                state_nx = V2;
            end
            V2: begin
                ram_addr = cur_attr;
                state_nx = V3;
            end
            V3: state_nx = IDLE;
            C1: begin
                ram_addr  = cpu_addr_q;
                ram_we    = cpu_we_q;
                ram_wdata = cpu_wdata_q;
                state_nx  = C2;
            end
            C2: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered-read 8K x 8 RAM model.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [12:0] vid_bmp_addr = '0;
    logic [12:0] vid_attr_addr = '0;
    logic [7:0]  vid_bmp_data, vid_attr_data;
    logic        vid_valid, vid_overrun;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;

    logic        pre_we = 1'b0;
    logic [12:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    logic [7:0]  mem [0:8191];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [12:0] b;
        logic [12:0] a;
        logic [7:0]  eb;
        logic [7:0]  ea;
    } vid_vec_t;

    typedef struct {
        bit          we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } cpu_vec_t;

    vid_vec_t vv[3];
    cpu_vec_t cv[8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (ram_we)
            mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    vram_arbiter #(.AW(13), .DW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_bmp_addr(vid_bmp_addr), .vid_attr_addr(vid_attr_addr),
        .vid_bmp_data(vid_bmp_data), .vid_attr_data(vid_attr_data),
        .vid_valid(vid_valid), .vid_overrun(vid_overrun),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick;
        pre_we   = 1'b0;
    endtask

    task automatic vid_fetch(input vid_vec_t v);
        int cyc;
        vid_bmp_addr  = v.b;
        vid_attr_addr = v.a;
        vid_req = 1'b1;
        tick;
        vid_req = 1'b0;
        cyc = 1;
        while (!vid_valid && cyc < 12) begin
            tick;
            cyc++;
        end
        check("vid_latency", cyc, 4);
        check("vid_bmp_data", int'(vid_bmp_data), int'(v.eb));
        check("vid_attr_data", int'(vid_attr_data), int'(v.ea));
        tick;
        check("vid_valid_one_cycle", int'(vid_valid), 0);
        check("vid_bmp_hold", int'(vid_bmp_data), int'(v.eb));
        check("vid_attr_hold", int'(vid_attr_data), int'(v.ea));
    endtask

    task automatic cpu_op(input cpu_vec_t v);
        int cyc;
        int wes;
        cpu_we    = v.we;
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_req   = 1'b1;
        tick;
        cyc = 1;
        wes = 0;
        while (!cpu_ack && cyc < 12) begin
            wes += int'(ram_we);
            tick;
            cyc++;
        end
        cpu_req = 1'b0;
        check("cpu_latency", cyc, 3);
        check("cpu_rdata", int'(cpu_rdata), int'(v.exp_rdata));
        check("cpu_we_cycles", wes, v.we ? 1 : 0);
        tick;
        check("cpu_ack_one_cycle", int'(cpu_ack), 0);
    endtask

    initial begin
        int vcyc, ccyc, v2cyc, bad_ack;
        logic [7:0] rd, b1, a1, b2, a2;

        vv[0] = '{13'h0123, 13'h1845, 8'hA5, 8'h3C};
        vv[1] = '{13'h17FF, 13'h1AFF, 8'hC3, 8'h81};
        vv[2] = '{13'h0000, 13'h1800, 8'h01, 8'hFE};

        cv[0] = '{1'b1, 13'h1AFF, 8'h5A, 8'h00};
        cv[1] = '{1'b0, 13'h1AFF, 8'h00, 8'h5A};
        cv[2] = '{1'b1, 13'h0000, 8'h11, 8'h5A};
        cv[3] = '{1'b1, 13'h1FFF, 8'hEE, 8'h5A};
        cv[4] = '{1'b0, 13'h0000, 8'h00, 8'h11};
        cv[5] = '{1'b0, 13'h1FFF, 8'h00, 8'hEE};
        cv[6] = '{1'b1, 13'h1800, 8'h77, 8'hEE};
        cv[7] = '{1'b0, 13'h1800, 8'h00, 8'h77};

        for (int i = 0; i < 3; i++) begin
            preload(vv[i].b, vv[i].eb);
            preload(vv[i].a, vv[i].ea);
        end

        // Reset state
        check("rst_vid_valid", int'(vid_valid), 0);
        check("rst_vid_overrun", int'(vid_overrun), 0);
        check("rst_vid_bmp", int'(vid_bmp_data), 0);
        check("rst_vid_attr", int'(vid_attr_data), 0);
        check("rst_cpu_ack", int'(cpu_ack), 0);
        check("rst_cpu_rdata", int'(cpu_rdata), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        check("rst_ram_we", int'(ram_we), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick;

        for (int i = 0; i < 3; i++)
            vid_fetch(vv[i]);

        // Video request arriving while a CPU write sits in C1
        cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'h42; cpu_req = 1'b1;
        tick;
        vid_bmp_addr = vv[2].b; vid_attr_addr = vv[2].a; vid_req = 1'b1;
        tick;
        vid_req = 1'b0;
        vcyc = 0; ccyc = 0;
        for (int cyc = 2; cyc < 16; cyc++) begin
            if (cpu_ack && ccyc == 0) begin ccyc = cyc; cpu_req = 1'b0; end
            if (vid_valid && vcyc == 0) vcyc = cyc;
            if (vcyc != 0 && ccyc != 0) break;
            tick;
        end
        check("vdc_cpu_ack_cycle", ccyc, 3);
        check("vdc_vid_valid_cycle", vcyc, 7);
        check("vdc_vid_bmp", int'(vid_bmp_data), int'(vv[2].eb));
        check("vdc_overrun", int'(vid_overrun), 0);
        tick;

        // Simultaneous CPU read and video request: video goes first
        cpu_we = 1'b0; cpu_addr = 13'h0123; cpu_req = 1'b1;
        vid_bmp_addr = vv[1].b; vid_attr_addr = vv[1].a; vid_req = 1'b1;
        tick;
        vid_req = 1'b0;
        vcyc = 0; ccyc = 0; rd = '0;
        for (int cyc = 1; cyc < 16; cyc++) begin
            if (vid_valid && vcyc == 0) vcyc = cyc;
            if (cpu_ack && ccyc == 0) begin ccyc = cyc; cpu_req = 1'b0; rd = cpu_rdata; end
            if (vcyc != 0 && ccyc != 0) break;
            tick;
        end
        check("col_vid_valid_cycle", vcyc, 4);
        check("col_cpu_ack_cycle", ccyc, 7);
        check("col_cpu_rdata", int'(rd), 8'hA5);
        check("col_vid_attr", int'(vid_attr_data), int'(vv[1].ea));
        tick;

        // Three back-to-back requests: second is overwritten by the third
        vid_bmp_addr = vv[0].b; vid_attr_addr = vv[0].a; vid_req = 1'b1;
        tick;
        vid_bmp_addr = vv[2].b; vid_attr_addr = vv[2].a;
        tick;
        vid_bmp_addr = vv[1].b; vid_attr_addr = vv[1].a;
        tick;
        vid_req = 1'b0;
        vcyc = 0; v2cyc = 0; b1 = '0; a1 = '0; b2 = '0; a2 = '0;
        for (int cyc = 3; cyc < 20; cyc++) begin
            if (vid_valid) begin
                if (vcyc == 0) begin vcyc = cyc; b1 = vid_bmp_data; a1 = vid_attr_data; end
                else if (v2cyc == 0) begin v2cyc = cyc; b2 = vid_bmp_data; a2 = vid_attr_data; end
            end
            if (v2cyc != 0) break;
            tick;
        end
        check("ovr_first_cycle", vcyc, 4);
        check("ovr_first_bmp", int'(b1), int'(vv[0].eb));
        check("ovr_first_attr", int'(a1), int'(vv[0].ea));
        check("ovr_second_cycle", v2cyc, 8);
        check("ovr_second_bmp", int'(b2), int'(vv[1].eb));
        check("ovr_second_attr", int'(a2), int'(vv[1].ea));
        check("ovr_flag", int'(vid_overrun), 1);
        for (int i = 0; i < 3; i++) tick;
        check("ovr_sticky", int'(vid_overrun), 1);

        // Reset in the middle of a CPU write
        cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'h99; cpu_req = 1'b1;
        tick;
        check("mid_c1_we", int'(ram_we), 1);
        #1 reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        check("mid_ram_we", int'(ram_we), 0);
        check("mid_ram_addr", int'(ram_addr), 0);
        check("mid_overrun", int'(vid_overrun), 0);
        check("mid_vid_bmp", int'(vid_bmp_data), 0);
        check("mid_vid_attr", int'(vid_attr_data), 0);
        check("mid_cpu_rdata", int'(cpu_rdata), 0);
        bad_ack = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            bad_ack += int'(cpu_ack);
        end
        check("mid_no_ack", bad_ack, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick;
        check("post_rst_no_ack", int'(cpu_ack), 0);
        vid_fetch(vv[0]);

        for (int i = 0; i < 8; i++)
            cpu_op(cv[i]);
        check("final_overrun", int'(vid_overrun), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
